// File: rtl/st_frame_dma_writer.sv
// Avalon-ST word stream to Avalon-MM burst writer filling a repeating frame buffer.
// Optional define DMA_SOP_SYNC_EN: each frame starts at the next st_startofpacket word.
module st_frame_dma_writer #(
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                  clk_sys,
   input  logic                  rst_sys_n,
   input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
   input  logic [29:0]           cfg_words_number,
   input  logic                  cfg_enable,
   input  logic [31:0]           st_data,
   input  logic                  st_valid,
   input  logic                  st_startofpacket,
   input  logic                  st_endofpacket,
   output logic                  st_ready,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_write,
   output logic [31:0]           avm_writedata,
   output logic [3:0]            avm_byteenable,
   output logic [6:0]            avm_burstcount,
   input  logic                  avm_waitrequest,
   output logic                  status_busy,
   output logic                  status_frame_done,
   output logic                  status_overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;
   localparam logic [PTR_W:0]   CNT_FULL = FIFO_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {IDLE, ARM, WAIT_DATA, BURST} state_t;
   state_t state;

   logic [31:0]           fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        fifo_count;
   logic                  fifo_full, push, pop, sop_ok, rdy_en;
   logic                  enable_d, en_rise, frame_end;
   logic [ADDR_WIDTH-1:0] cur_addr, cfg_addr_lat;
   logic [29:0]           remaining, cfg_words_lat;
   logic [6:0]            blen, blen_now, beats_left;
   logic                  unused_inputs;

   assign en_rise        = cfg_enable & ~enable_d;
   assign fifo_full      = (fifo_count == CNT_FULL);
   assign blen_now       = (remaining >= 30'(BURST_LEN)) ? 7'(BURST_LEN) : remaining[6:0];
   assign pop            = (state == BURST) & ~avm_waitrequest;
   assign frame_end      = pop & (beats_left == 7'd1) & (remaining == {23'd0, blen});
   assign push           = st_valid & st_ready & (state != IDLE) & sop_ok;
   assign status_busy    = (state != IDLE);
   assign avm_byteenable = 4'hF;
   assign avm_writedata  = avm_write ? fifo_mem[rd_ptr] : 32'd0;

`ifdef DMA_SOP_SYNC_EN
   logic hunting;

   // While hunting, non-SOP words are swallowed so the frame starts on an SOP word.
   assign sop_ok        = ~hunting | st_startofpacket;
   assign st_ready      = rdy_en & ((state == IDLE) | (hunting & ~st_startofpacket) | ~fifo_full);
   assign unused_inputs = st_endofpacket;

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n)
         hunting <= 1'b1;
      else if (state == IDLE || frame_end)
         hunting <= 1'b1;
      else if (push)
         hunting <= 1'b0;
   end
`else
   assign sop_ok        = 1'b1;
   assign st_ready      = rdy_en & ((state == IDLE) | ~fifo_full);
   assign unused_inputs = st_endofpacket ^ st_startofpacket;
`endif

   // Show-ahead word FIFO; held empty whenever the engine is idle.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (state == IDLE) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            fifo_count <= fifo_count + CNT_ONE;
         else if (pop && !push)
            fifo_count <= fifo_count - CNT_ONE;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push)
         fifo_mem[wr_ptr] <= st_data;
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state             <= IDLE;
         rdy_en            <= 1'b0;
         enable_d          <= 1'b0;
         cur_addr          <= '0;
         cfg_addr_lat      <= '0;
         remaining         <= '0;
         cfg_words_lat     <= '0;
         blen              <= '0;
         beats_left        <= '0;
         avm_address       <= '0;
         avm_burstcount    <= '0;
         avm_write         <= 1'b0;
         status_frame_done <= 1'b0;
         status_overflow   <= 1'b0;
      end else begin
         rdy_en            <= 1'b1;
         enable_d          <= cfg_enable;
         status_frame_done <= 1'b0;
         if (en_rise)
            status_overflow <= 1'b0;
         else if (st_valid && !st_ready && state != IDLE)
            status_overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (en_rise) begin
                  cur_addr      <= cfg_start_addr;
                  cfg_addr_lat  <= cfg_start_addr;
                  remaining     <= cfg_words_number;
                  cfg_words_lat <= cfg_words_number;
                  state         <= ARM;
               end
            end
            ARM: begin
               if (remaining == '0) begin
                  status_frame_done <= 1'b1;
                  state             <= IDLE;
               end else begin
                  state <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (!cfg_enable) begin
                  state <= IDLE;
               end else if (32'(fifo_count) >= 32'(blen_now)) begin
                  avm_address    <= cur_addr;
                  avm_burstcount <= blen_now;
                  blen           <= blen_now;
                  beats_left     <= blen_now;
                  avm_write      <= 1'b1;
                  state          <= BURST;
               end
            end
            BURST: begin
               // A started burst always runs to completion; disable is honoured afterwards.
               if (!avm_waitrequest) begin
                  beats_left <= beats_left - 7'd1;
                  if (beats_left == 7'd1) begin
                     avm_write <= 1'b0;
                     if (frame_end) begin
                        status_frame_done <= 1'b1;
                        cur_addr          <= cfg_addr_lat;
                        remaining         <= cfg_words_lat;
                     end else begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'({blen, 2'b00});
                        remaining <= remaining - {23'd0, blen};
                     end
                     state <= cfg_enable ? WAIT_DATA : IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_st_frame_dma_writer.sv
// Self-checking bench for st_frame_dma_writer: a burst/word plan model checked on every write cycle.
// Build with DMA_SOP_SYNC_EN defined to also exercise start-of-packet alignment.
module tb_st_frame_dma_writer;
   logic        clk_sys = 1'b0;
   logic        rst_sys_n;
   logic [31:0] cfg_start_addr;
   logic [29:0] cfg_words_number;
   logic        cfg_enable;
   logic [31:0] st_data;
   logic        st_valid, st_startofpacket, st_endofpacket;
   logic        st_ready;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [6:0]  avm_burstcount;
   logic        avm_waitrequest = 1'b0;
   logic        status_busy, status_frame_done, status_overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int wait_mode = 0;
   int fd_count = 0;
   int fd_base;

   logic [31:0] exp_addr [$];
   logic [6:0]  exp_cnt  [$];
   logic [31:0] exp_data [$];

   logic        in_burst = 1'b0;
   logic [31:0] burst_addr;
   logic [6:0]  burst_cnt;
   int          beat_idx = 0;

   st_frame_dma_writer dut (
      .clk_sys           (clk_sys),
      .rst_sys_n         (rst_sys_n),
      .cfg_start_addr    (cfg_start_addr),
      .cfg_words_number  (cfg_words_number),
      .cfg_enable        (cfg_enable),
      .st_data           (st_data),
      .st_valid          (st_valid),
      .st_startofpacket  (st_startofpacket),
      .st_endofpacket    (st_endofpacket),
      .st_ready          (st_ready),
      .avm_address       (avm_address),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_burstcount    (avm_burstcount),
      .avm_waitrequest   (avm_waitrequest),
      .status_busy       (status_busy),
      .status_frame_done (status_frame_done),
      .status_overflow   (status_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // Slave model: 0 = always ready, 1 = random 50% stall, 2 = stall forever.
   always begin
      @(posedge clk_sys);
      #1;
      case (wait_mode)
         1:       avm_waitrequest = 1'($urandom_range(0, 1));
         2:       avm_waitrequest = 1'b1;
         default: avm_waitrequest = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Expected writes for n words of a frame: bursts of up to 16 beats, 4 bytes per word.
   task automatic planFrame(input logic [31:0] start, input int words, input logic [31:0] first);
      int rem = words;
      logic [31:0] a = start;
      logic [31:0] d = first;
      while (rem > 0) begin
         int n = (rem < 16) ? rem : 16;
         exp_addr.push_back(a);
         exp_cnt.push_back(7'(n));
         for (int i = 0; i < n; i++) begin
            exp_data.push_back(d);
            d = d + 32'd1;
         end
         a = a + 32'(4 * n);
         rem = rem - n;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] data, input logic sop, input logic eop);
      st_data          = data;
      st_startofpacket = sop;
      st_endofpacket   = eop;
      st_valid         = 1'b1;
      tick();
      st_valid         = 1'b0;
      st_startofpacket = 1'b0;
      st_endofpacket   = 1'b0;
   endtask

   task automatic streamWords(input logic [31:0] base, input int n, input logic sop_first);
      for (int i = 0; i < n; i++)
         applyStimulus(base + 32'(i), sop_first && (i == 0), i == n - 1);
   endtask

   task automatic startFrame(input logic [31:0] addr, input logic [29:0] words);
      cfg_enable = 1'b0;
      tick();
      tick();
      cfg_start_addr   = addr;
      cfg_words_number = words;
      cfg_enable       = 1'b1;
      tick();
      tick();
   endtask

   task automatic waitDrain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_data.size() == 0 && !in_burst)
            break;
         tick();
      end
      checkOutput("drain_pending_words", 64'(exp_data.size()), 64'd0);
   endtask

   task automatic waitIdle(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (!status_busy)
            break;
         tick();
      end
      checkOutput("busy_returns_idle", 64'(status_busy), 64'd0);
   endtask

   // Compare process: every write-cycle is checked against the planned bursts and words.
   always @(negedge clk_sys) begin
      if (rst_sys_n) begin
         if (status_frame_done)
            fd_count++;
         if (avm_write) begin
            if (!in_burst) begin
               if (exp_addr.size() == 0) begin
                  checkOutput("unexpected_burst", 64'(avm_address), 64'hFFFF_FFFF_FFFF_FFFF);
                  burst_addr = avm_address;
                  burst_cnt  = avm_burstcount;
               end else begin
                  burst_addr = exp_addr.pop_front();
                  burst_cnt  = exp_cnt.pop_front();
                  checkOutput("burst_address", 64'(avm_address), 64'(burst_addr));
                  checkOutput("burst_count", 64'(avm_burstcount), 64'(burst_cnt));
               end
               in_burst = 1'b1;
               beat_idx = 0;
            end else begin
               checkOutput("address_stable", 64'(avm_address), 64'(burst_addr));
               checkOutput("burstcount_stable", 64'(avm_burstcount), 64'(burst_cnt));
            end
            if (!avm_waitrequest) begin
               checkOutput("byteenable", 64'(avm_byteenable), 64'hF);
               if (exp_data.size() == 0)
                  checkOutput("unexpected_beat", 64'(avm_writedata), 64'hFFFF_FFFF_FFFF_FFFF);
               else
                  checkOutput("beat_data", 64'(avm_writedata), 64'(exp_data.pop_front()));
               beat_idx++;
               if (beat_idx >= int'(burst_cnt))
                  in_burst = 1'b0;
            end
         end else if (in_burst) begin
            checkOutput("write_dropped_mid_burst", 64'(avm_write), 64'd1);
            in_burst = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_sys_n        = 1'b0;
      cfg_start_addr   = 32'd0;
      cfg_words_number = 30'd0;
      cfg_enable       = 1'b0;
      st_data          = 32'd0;
      st_valid         = 1'b0;
      st_startofpacket = 1'b0;
      st_endofpacket   = 1'b0;
      tick();
      tick();

      // Reset values
      checkOutput("rst_st_ready", 64'(st_ready), 64'd0);
      checkOutput("rst_avm_write", 64'(avm_write), 64'd0);
      checkOutput("rst_avm_address", 64'(avm_address), 64'd0);
      checkOutput("rst_burstcount", 64'(avm_burstcount), 64'd0);
      checkOutput("rst_writedata", 64'(avm_writedata), 64'd0);
      checkOutput("rst_byteenable", 64'(avm_byteenable), 64'hF);
      checkOutput("rst_busy", 64'(status_busy), 64'd0);
      checkOutput("rst_frame_done", 64'(status_frame_done), 64'd0);
      checkOutput("rst_overflow", 64'(status_overflow), 64'd0);
      rst_sys_n = 1'b1;
      tick();
      tick();
      checkOutput("idle_st_ready", 64'(st_ready), 64'd1);

      // Words offered while idle are discarded without overflow
      streamWords(32'hBAD0, 4, 1'b0);
      checkOutput("idle_no_overflow", 64'(status_overflow), 64'd0);

      // 40-word frame at 0x1000, no stalls
      $display("[TB] frame of 40 words at 0x1000");
      planFrame(32'h1000, 40, 32'd0);
      checkOutput("model_b0_addr", 64'(exp_addr[0]), 64'h1000);
      checkOutput("model_b0_cnt", 64'(exp_cnt[0]), 64'd16);
      checkOutput("model_b1_addr", 64'(exp_addr[1]), 64'h1040);
      checkOutput("model_b2_addr", 64'(exp_addr[2]), 64'h1080);
      checkOutput("model_b2_cnt", 64'(exp_cnt[2]), 64'd8);
      checkOutput("model_last_word", 64'(exp_data[39]), 64'd39);
      fd_base = fd_count;
      startFrame(32'h1000, 30'd40);
      checkOutput("busy_after_enable", 64'(status_busy), 64'd1);
      streamWords(32'd0, 40, 1'b1);
      waitDrain(200);
      tick();
      tick();
      tick();
      checkOutput("frame_done_once", 64'(fd_count - fd_base), 64'd1);
      checkOutput("no_overflow_f1", 64'(status_overflow), 64'd0);
      cfg_enable = 1'b0;
      tick();
      waitIdle(20);

      // Same frame length, slave stalls randomly
      $display("[TB] 40 words at 0x2000 with random waitrequest");
      wait_mode = 1;
      planFrame(32'h2000, 40, 32'd100);
      fd_base = fd_count;
      startFrame(32'h2000, 30'd40);
      streamWords(32'd100, 40, 1'b1);
      waitDrain(500);
      tick();
      tick();
      tick();
      checkOutput("frame_done_random", 64'(fd_count - fd_base), 64'd1);
      wait_mode = 0;
      cfg_enable = 1'b0;
      tick();
      waitIdle(20);

      // Zero-length frame: one pulse, no writes, back to idle
      $display("[TB] zero-length frame");
      fd_base = fd_count;
      startFrame(32'h6000, 30'd0);
      tick();
      tick();
      tick();
      checkOutput("zero_len_frame_done", 64'(fd_count - fd_base), 64'd1);
      checkOutput("zero_len_busy", 64'(status_busy), 64'd0);

      // Disable at beat 5: burst finishes, leftover words are flushed
      $display("[TB] disable in the middle of a burst");
      wait_mode = 2;
      planFrame(32'h3000, 16, 32'd300);
      startFrame(32'h3000, 30'd40);
      streamWords(32'd300, 20, 1'b1);
      wait_mode = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (in_burst && beat_idx >= 5)
            break;
      end
      checkOutput("reached_mid_burst", 64'(in_burst), 64'd1);
      cfg_enable = 1'b0;
      tick();
      waitIdle(50);
      checkOutput("mid_burst_all_beats", 64'(exp_data.size()), 64'd0);
      checkOutput("disabled_st_ready", 64'(st_ready), 64'd1);
      planFrame(32'h4000, 16, 32'd400);
      startFrame(32'h4000, 30'd16);
      streamWords(32'd400, 16, 1'b1);
      waitDrain(200);
      cfg_enable = 1'b0;
      tick();
      waitIdle(20);

      // Stalled slave: FIFO fills and further words are dropped
      $display("[TB] overflow with stalled slave");
      wait_mode = 2;
      planFrame(32'h5000, 16, 32'd500);
      startFrame(32'h5000, 30'd1000);
      streamWords(32'd500, 64, 1'b1);
      checkOutput("full_no_overflow_yet", 64'(status_overflow), 64'd0);
      checkOutput("full_st_ready_low", 64'(st_ready), 64'd0);
      streamWords(32'd564, 16, 1'b0);
      checkOutput("overflow_set", 64'(status_overflow), 64'd1);
      cfg_enable = 1'b0;
      tick();
      wait_mode = 0;
      waitIdle(100);
      checkOutput("overflow_drain", 64'(exp_data.size()), 64'd0);
      checkOutput("overflow_sticky", 64'(status_overflow), 64'd1);
      fd_base = fd_count;
      startFrame(32'h6000, 30'd0);
      checkOutput("overflow_cleared", 64'(status_overflow), 64'd0);
      tick();
      tick();
      checkOutput("clear_frame_done", 64'(fd_count - fd_base), 64'd1);

`ifdef DMA_SOP_SYNC_EN
      // Junk before SOP is skipped; the SOP word lands at the start address
      $display("[TB] start-of-packet alignment");
      planFrame(32'h7000, 16, 32'hA5);
      startFrame(32'h7000, 30'd16);
      streamWords(32'hDEAD_0000, 3, 1'b0);
      streamWords(32'hA5, 16, 1'b1);
      waitDrain(200);
      cfg_enable = 1'b0;
      tick();
      waitIdle(20);
`endif

      tick();
      tick();
      checkOutput("unconsumed_bursts", 64'(exp_addr.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
